// File: rtl/sar_sequencer.sv
// SAR ADC conversion sequencer: trigger handling, binary-search DAC stepping,
// periodic trigger timer and a first-word-fall-through result FIFO.
module sar_sequencer #(
    parameter int unsigned N_BITS     = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic              cont_i,
    input  logic [15:0]       period_i,
    input  logic [3:0]        settle_i,
    input  logic              comp_in,
    output logic              sample_o,
    output logic [N_BITS-1:0] dac_code_o,
    output logic              busy_o,
    output logic              eoc_o,
    output logic [N_BITS-1:0] res_data_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic              ovf_o,
    output logic              miss_o,
    input  logic              clr_i
);

    localparam int unsigned BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        settle_q, settle_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [N_BITS-1:0] code_q, code_d;
    logic [15:0]       timer_q, timer_d;
    logic              sample_q, sample_d;
    logic              busy_q, busy_d;
    logic              eoc_q, eoc_d;
    logic              miss_q, miss_d;
    logic              ovf_q, ovf_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [N_BITS-1:0] head_q, head_d;
    logic              valid_q, valid_d;
    logic [N_BITS-1:0] mem_q [FIFO_DEPTH];

    logic [15:0]       reload_c;
    logic              timer_exp_c;
    logic              trig_c;
    logic [N_BITS-1:0] trial_mask_c;
    logic [N_BITS-1:0] resolved_c;
    logic              push_c;
    logic              pop_c;
    logic              full_c;
    logic              wr_en_c;

    // Trigger sources and periodic timer
    always_comb begin
        reload_c    = (period_i == 16'd0) ? 16'd1 : period_i;
        timer_exp_c = cont_i && (timer_q == 16'd1);
        trig_c      = start_i || timer_exp_c;
        timer_d     = timer_q;
        if (!cont_i || (timer_q == 16'd1)) begin
            timer_d = reload_c;
        end else begin
            timer_d = timer_q - 16'd1;
        end
    end

    // Conversion FSM: next state and registered outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        settle_d     = settle_q;
        bit_d        = bit_q;
        code_d       = code_q;
        trial_mask_c = N_BITS'(1) << bit_q;
        resolved_c   = comp_in ? code_q : (code_q & ~trial_mask_c);
        case (state_q)
            IDLE: begin
                if (trig_c) begin
                    state_d  = SAMPLE;
                    settle_d = settle_i;
                    cnt_d    = 4'd0;
                    code_d   = '0;
                end
            end
            SAMPLE: begin
                if (cnt_q == settle_q) begin
                    state_d = CONVERT;
                    cnt_d   = 4'd0;
                    bit_d   = BW'(N_BITS - 1);
                    code_d  = N_BITS'(1) << (N_BITS - 1);
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CONVERT: begin
                if (cnt_q == settle_q) begin
                    cnt_d = 4'd0;
                    if (bit_q == '0) begin
                        state_d = DONE;
                        code_d  = resolved_c;
                    end else begin
                        bit_d  = bit_q - BW'(1);
                        code_d = resolved_c | (N_BITS'(1) << (bit_q - BW'(1)));
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        sample_d = (state_d == SAMPLE);
        busy_d   = (state_d != IDLE);
        eoc_d    = (state_d == DONE);
    end

    // Result FIFO bookkeeping and sticky flags; the head is kept in a register
    always_comb begin
        push_c   = (state_q == DONE);
        pop_c    = valid_q && res_ready_i;
        full_c   = (count_q == CW'(FIFO_DEPTH));
        wr_en_c  = push_c && (!full_c || pop_c);
        wr_ptr_d = wr_en_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr_en_c) - CW'(pop_c);
        valid_d  = (count_d != '0);
        head_d   = '0;
        if (count_d != '0) begin
            if (wr_en_c && (rd_ptr_d == wr_ptr_q)) begin
                head_d = code_q;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
        ovf_d  = ovf_q;
        miss_d = miss_q;
        if (clr_i) begin
            ovf_d  = 1'b0;
            miss_d = 1'b0;
        end
        if (push_c && full_c && !pop_c) begin
            ovf_d = 1'b1;
        end
        if (trig_c && (state_q != IDLE)) begin
            miss_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            settle_q <= 4'd0;
            bit_q    <= '0;
            code_q   <= '0;
            timer_q  <= reload_c;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            eoc_q    <= 1'b0;
            miss_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            bit_q    <= bit_d;
            code_q   <= code_d;
            timer_q  <= timer_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            eoc_q    <= eoc_d;
            miss_q   <= miss_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && wr_en_c) begin
            mem_q[wr_ptr_q] <= code_q;
        end
    end

    assign sample_o    = sample_q;
    assign dac_code_o  = code_q;
    assign busy_o      = busy_q;
    assign eoc_o       = eoc_q;
    assign res_data_o  = head_q;
    assign res_valid_o = valid_q;
    assign ovf_o       = ovf_q;
    assign miss_o      = miss_q;

endmodule

// File: tb/tb_sar_sequencer.sv
// Directed bench for sar_sequencer: a scoreboard queues expected EOC cycles
// and FIFO results as conversions are launched; a monitor pops and compares.
module tb_sar_sequencer;

    localparam int unsigned N = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i, cont_i, comp_in, res_ready_i, clr_i;
    logic [15:0]   period_i;
    logic [3:0]    settle_i;
    logic          sample_o, busy_o, eoc_o, res_valid_o, ovf_o, miss_o;
    logic [N-1:0]  dac_code_o, res_data_o;
    logic [N-1:0]  vin;

    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;
    int            exp_eoc[$];
    logic [N-1:0]  exp_data[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Ideal comparator: Vin >= DAC
    always_comb comp_in = (vin >= dac_code_o);

    sar_sequencer #(.N_BITS(N), .FIFO_DEPTH(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i), .cont_i(cont_i),
        .period_i(period_i), .settle_i(settle_i), .comp_in(comp_in),
        .sample_o(sample_o), .dac_code_o(dac_code_o), .busy_o(busy_o),
        .eoc_o(eoc_o), .res_data_o(res_data_o), .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i), .ovf_o(ovf_o), .miss_o(miss_o), .clr_i(clr_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: EOC timing and popped FIFO data
    always @(negedge clk) begin
        if (eoc_o === 1'b1) begin
            if (exp_eoc.size() == 0) check("eoc_unexpected", 32'(eoc_o), 32'd0);
            else check("eoc_latency", 32'(cyc), 32'(exp_eoc.pop_front()));
        end
        if (res_valid_o === 1'b1 && res_ready_i === 1'b1 && rst === 1'b0) begin
            if (exp_data.size() == 0) check("pop_unexpected", 32'(res_valid_o), 32'd0);
            else check("pop_data", 32'(res_data_o), 32'(exp_data.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic start_conv(input logic [N-1:0] v, input logic [3:0] s, input bit pushed);
        vin      = v;
        settle_i = s;
        start_i  = 1'b1;
        exp_eoc.push_back(cyc + int'((N + 1) * (int'(s) + 1) + 1));
        if (pushed) exp_data.push_back(v);
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(busy_o), 32'd0);
    endtask

    initial begin
        logic [N-1:0] seq [10];
        logic [N-1:0] fv [7];
        int k;
        seq = '{10'h200, 10'h300, 10'h280, 10'h2C0, 10'h2A0,
                10'h2B0, 10'h2A8, 10'h2A4, 10'h2A6, 10'h2A5};
        fv  = '{10'h011, 10'h0F2, 10'h133, 10'h3C4, 10'h255, 10'h066, 10'h377};

        rst = 1'b1; start_i = 1'b0; cont_i = 1'b0; period_i = 16'd5;
        settle_i = 4'd0; res_ready_i = 1'b1; clr_i = 1'b0; vin = '0;
        ticks(3);
        check("rst_sample", 32'(sample_o), 32'd0);
        check("rst_dac", 32'(dac_code_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_valid", 32'(res_valid_o), 32'd0);
        check("rst_data", 32'(res_data_o), 32'd0);
        check("rst_flags", {30'd0, ovf_o, miss_o}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic S=0 conversion with the DAC search sequence
        start_conv(10'h2A5, 4'd0, 1'b1);
        check("s0_sample", 32'(sample_o), 32'd1);
        check("s0_sample_dac", 32'(dac_code_o), 32'd0);
        check("s0_busy", 32'(busy_o), 32'd1);
        tick();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("s0_dac_%0d", i), 32'(dac_code_o), 32'(seq[i]));
            if (i == 0) check("s0_sample_low", 32'(sample_o), 32'd0);
            tick();
        end
        check("s0_final_dac", 32'(dac_code_o), 32'h2A5);
        check("s0_no_bypass", 32'(res_valid_o), 32'd0);
        tick();
        check("s0_fwft_valid", 32'(res_valid_o), 32'd1);
        check("s0_idle_dac", 32'(dac_code_o), 32'h2A5);
        tick();

        // S=1 extremes; settle_i changes mid-flight must not matter
        start_conv(10'h3FF, 4'd1, 1'b1);
        settle_i = 4'd0;
        check("s1_sample_c1", 32'(sample_o), 32'd1);
        tick();
        check("s1_sample_c2", 32'(sample_o), 32'd1);
        tick();
        check("s1_sample_c3", 32'(sample_o), 32'd0);
        wait_idle();
        start_conv(10'h000, 4'd1, 1'b1);
        wait_idle();
        settle_i = 4'd0;
        tick();

        // Back-to-back: trigger in DONE is a miss, next IDLE cycle is accepted
        start_conv(10'h123, 4'd0, 1'b1);
        ticks(11);
        start_i = 1'b1;
        check("b2b_done_eoc", 32'(eoc_o), 32'd1);
        check("b2b_miss_before", 32'(miss_o), 32'd0);
        tick();
        check("b2b_miss_set", 32'(miss_o), 32'd1);
        vin = 10'h0C7;
        exp_eoc.push_back(cyc + 12);
        exp_data.push_back(10'h0C7);
        tick();
        start_i = 1'b0;
        check("b2b_accepted", 32'(sample_o), 32'd1);
        wait_idle();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("b2b_miss_clr", 32'(miss_o), 32'd0);

        // Reset during bit phase 4 with one stored result
        res_ready_i = 1'b0;
        start_conv(10'h0F0, 4'd0, 1'b1);
        wait_idle();
        check("rst_pre_valid", 32'(res_valid_o), 32'd1);
        vin = 10'h1AB;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        ticks(2);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("rst_pre_miss", 32'(miss_o), 32'd1);
        ticks(3);
        check("rst_phase4_dac", 32'(dac_code_o), 32'h1B0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_data.delete();
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_dac", 32'(dac_code_o), 32'd0);
        check("midrst_valid", 32'(res_valid_o), 32'd0);
        check("midrst_eoc", 32'(eoc_o), 32'd0);
        check("midrst_miss", 32'(miss_o), 32'd0);
        res_ready_i = 1'b1;
        tick();
        start_conv(10'h1AB, 4'd0, 1'b1);
        wait_idle();
        tick();

        // Periodic mode, period 5: accepted triggers every 15 cycles
        k = cyc;
        cont_i = 1'b1;
        vin = 10'h155;
        for (int i = 0; i < 3; i++) begin
            exp_eoc.push_back(k + 16 + 15 * i);
            exp_data.push_back(10'h155);
        end
        ticks(9);
        check("per_miss_before", 32'(miss_o), 32'd0);
        tick();
        check("per_miss_set", 32'(miss_o), 32'd1);
        check("per_busy", 32'(busy_o), 32'd1);
        ticks(35);
        cont_i = 1'b0;
        wait_idle();
        ticks(10);
        check("per_stopped", 32'(busy_o), 32'd0);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;

        // FIFO overflow, then simultaneous push+pop while full
        res_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start_conv(fv[i], 4'd0, i < 4);
            wait_idle();
            if (i == 3) check("ovf_at_4", 32'(ovf_o), 32'd0);
        end
        check("ovf_at_5", 32'(ovf_o), 32'd1);
        check("full_head", 32'(res_data_o), 32'(fv[0]));
        start_conv(fv[5], 4'd0, 1'b1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        ticks(10);
        check("pp_eoc", 32'(eoc_o), 32'd1);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        check("pp_ovf_kept", 32'(ovf_o), 32'd1);
        check("pp_head", 32'(res_data_o), 32'(fv[1]));
        check("pp_miss", 32'(miss_o), 32'd1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("clr_ovf", 32'(ovf_o), 32'd0);
        check("clr_miss", 32'(miss_o), 32'd0);

        // clr_i colliding with a new overflow: set wins
        start_conv(fv[6], 4'd0, 1'b0);
        ticks(11);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("clr_vs_ovf", 32'(ovf_o), 32'd1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("clr_ovf2", 32'(ovf_o), 32'd0);

        // Drain: order v1,v2,v3,v5; extra ready on empty is harmless
        res_ready_i = 1'b1;
        ticks(8);
        check("drained", 32'(res_valid_o), 32'd0);
        check("drained_data", 32'(res_data_o), 32'd0);
        check("eoc_queue_empty", 32'(exp_eoc.size()), 32'd0);
        check("data_queue_empty", 32'(exp_data.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sar_sequencer.md
SAR_SEQUENCER -- requirements
Module: sar_sequencer

Interface
REQ-001 Parameter N_BITS, default 10: conversion resolution in bits.
REQ-002 Parameter FIFO_DEPTH, default 4: result FIFO entries, power of two.
REQ-003 Port wb_clk_i, input, 1: sole clock; all logic is rising-edge.
REQ-004 Port wb_rst_i, input, 1: reset, synchronous, active-high.
REQ-005 Port start_i, input, 1: single-shot conversion request; level sampled each cycle.
REQ-006 Port cont_i, input, 1: continuous-mode enable for the periodic trigger.
REQ-007 Port period_i, input, 16: periodic trigger interval in cycles; 0 is treated as 1.
REQ-008 Port settle_i, input, 4: S, extra settle cycles per phase; each phase lasts S+1 cycles.
REQ-009 Port comp_in, input, 1: comparator output, synchronous to wb_clk_i; 1 means Vin >= DAC.
REQ-010 Port sample_o, output, 1: sample switch enable.
REQ-011 Port dac_code_o, output, N_BITS: trial code driven to the capacitive DAC.
REQ-012 Port busy_o, output, 1: high in any state other than IDLE.
REQ-013 Port eoc_o, output, 1: one-cycle end-of-conversion pulse.
REQ-014 Port res_data_o, output, N_BITS: FIFO head data.
REQ-015 Port res_valid_o, output, 1: FIFO not empty.
REQ-016 Port res_ready_i, input, 1: consumer pop; a pop occurs on any cycle with res_valid_o and res_ready_i both high.
REQ-017 Port ovf_o, output, 1: sticky flag, result dropped because the FIFO was full.
REQ-018 Port miss_o, output, 1: sticky flag, trigger dropped because the block was busy.
REQ-019 Port clr_i, input, 1: one-cycle clear of ovf_o and miss_o.

Function
REQ-020 FSM states: IDLE, SAMPLE, CONVERT, DONE.
- IDLE->SAMPLE on a trigger.
- SAMPLE->CONVERT after S+1 cycles.
- CONVERT->DONE after N_BITS bit phases.
- DONE->IDLE after 1 cycle.
REQ-021 Trigger: start_i high in IDLE, or periodic-timer expiry in IDLE; both in the same cycle count as one trigger.
REQ-022 SAMPLE: sample_o=1 and dac_code_o=0; sample_o is 0 in every other state.
REQ-023 Bit phases run from bit N_BITS-1 down to 0.
- Each phase lasts S+1 cycles.
- dac_code_o = resolved upper bits | trial bit set | lower bits 0.
REQ-024 comp_in is sampled on the last cycle of each bit phase: 1 keeps the trial bit, 0 clears it.
REQ-025 DONE: the final code is pushed into the FIFO and eoc_o pulses in the same cycle.
REQ-026 In IDLE, dac_code_o holds the last final code.
REQ-027 Latency: eoc_o asserts exactly (N_BITS+1)*(S+1)+1 cycles after the trigger cycle.
- S=0, N_BITS=10 gives 12 cycles.
- settle_i is captured at the trigger; later changes do not affect the conversion in flight.
REQ-028 Triggers arriving while busy_o=1 (start_i or timer) are ignored; each one sets miss_o. Back-to-back operation: a trigger in the DONE cycle is a miss; a trigger in the following IDLE cycle is accepted.
REQ-029 Periodic timer, cont_i=1:
- Down-counter loaded with max(period_i,1).
- Expires when it reaches 1, issues a trigger, then reloads.
REQ-030 Periodic timer, cont_i=0: the counter holds at its reload value. Clearing cont_i never aborts a conversion in flight.
REQ-031 FIFO organisation: first-word-fall-through. Data pushed at cycle k is visible on res_data_o with res_valid_o=1 from cycle k+1; there is no same-cycle bypass.
REQ-032 FIFO full: a push when full with no pop in the same cycle drops the new result, sets ovf_o, and leaves stored data unchanged.
REQ-033 FIFO full with simultaneous push and pop: both are performed, ovf_o is not set, and order is preserved.
REQ-034 FIFO pointers wrap modulo FIFO_DEPTH. res_ready_i while empty has no effect.
REQ-035 clr_i clears ovf_o and miss_o. A set event in the same cycle as clr_i wins, leaving the flag at 1.

Reset
REQ-036 wb_rst_i=1 at a clock edge forces the following, regardless of state (including mid-conversion):
- state IDLE; sample_o=0; dac_code_o=0; busy_o=0; eoc_o=0;
- FIFO empty, so res_valid_o=0 and res_data_o=0;
- ovf_o=0; miss_o=0; timer loaded with max(period_i,1).
REQ-037 No FIFO push and no eoc_o pulse occur in any cycle where wb_rst_i is sampled high.

Verification
REQ-038 S=0, comparator model comp_in=(0x2A5>=dac_code_o), start_i pulse -> eoc_o 12 cycles later, res_data_o=0x2A5, dac_code_o sequence 0x200,0x300,0x280,0x2C0,0x2A0,0x2B0,0x2A8,0x2A4,0x2A6,0x2A5.
REQ-039 S=1, Vin code 0x3FF then 0x000 -> each eoc_o 23 cycles after its trigger, results 0x3FF then 0x000, sample_o high 2 cycles.
REQ-040 cont_i=1, period_i=5, S=0 (conversion takes 12 cycles) -> every expiry during busy sets miss_o; accepted triggers are spaced 15 cycles apart.
REQ-041 res_ready_i=0, 5 conversions -> FIFO holds the first 4 results, ovf_o=1 after the 5th; then push and pop in the same full cycle -> ovf_o stays as-is and order is preserved.
REQ-042 wb_rst_i pulsed during bit phase 4 -> next cycle busy_o=0, dac_code_o=0, res_valid_o=0, no eoc_o; a new start_i converts correctly.
REQ-043 clr_i asserted in the same cycle as a new overflow -> ovf_o remains 1; clr_i alone -> ovf_o and miss_o become 0.
